// File: rtl/dense_relu.sv
// dense_relu: hidden dense layer with ReLU feeding the final argmax stage.
// Computes N Q1.15 activations from M Q1.15 inputs, one multiply-accumulate
// per cycle, then adds a bias, applies ReLU and saturates to 0..0x7FFF.
//
// Parameters: M inputs per vector, N outputs (both 1..255).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   x          input vector, element j at x[16j+15:16j]
//   weightsf   weight for (output o, input j) at index o*M+j, static while busy
//   biasesf    bias for output o at index o, static while busy
//   in_valid   x is valid
//   in_ready   block can accept x (IDLE only)
//   y          activation vector, element o at y[16o+15:16o]
//   out_valid  y is complete and held stable
//   out_ready  downstream accepts y
//
// Build option: define DENSE_RELU_ROUND_EN to round each product to nearest
// (ties toward +inf) instead of truncating toward -inf.
//
// state | meaning
// IDLE  | waiting for an input handshake
// MAC   | accumulating x[j]*w[o*M+j] for the current output o
// ACT   | bias + ReLU + saturation of output o, written into y
// DONE  | y presented downstream until out_ready
module dense_relu #(
  parameter int M = 10,
  parameter int N = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [16*M-1:0]    x,
  input  logic [16*M*N-1:0]  weightsf,
  input  logic [16*N-1:0]    biasesf,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [16*N-1:0]    y,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

  state_t              state_q;
  logic [16*M-1:0]     xr_q;
  logic [7:0]          j_q;
  logic [7:0]          o_q;
  logic signed [31:0]  acc_q;
  logic [16*N-1:0]     y_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [31:0]         w_idx;
  logic signed [15:0]  x_el;
  logic signed [15:0]  w_el;
  logic signed [15:0]  b_el;
  logic signed [31:0]  prod;
  logic signed [31:0]  term;
  logic signed [31:0]  acc_d;
  logic signed [31:0]  s_d;
  logic [15:0]         act_d;

  always_comb begin
    w_idx = 32'(o_q) * 32'(M) + 32'(j_q);
    x_el  = xr_q[16*j_q +: 16];
    w_el  = weightsf[16*w_idx +: 16];
    b_el  = biasesf[16*o_q +: 16];
    // Full-precision product of two Q1.15 values is Q2.30; shift back to Q1.15.
    prod  = 32'(x_el) * 32'(w_el);
`ifdef DENSE_RELU_ROUND_EN
    term  = (prod + 32'sd16384) >>> 15;
`else
    term  = prod >>> 15;
`endif
    acc_d = acc_q + term;
    s_d   = acc_q + {{16{b_el[15]}}, b_el};
    if (s_d <= 32'sd0) begin
      act_d = 16'h0000;
    end else if (s_d > 32'sd32767) begin
      act_d = 16'h7FFF;
    end else begin
      act_d = s_d[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      xr_q        <= '0;
      j_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            xr_q       <= x;
            acc_q      <= '0;
            j_q        <= '0;
            o_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (j_q == 8'(M-1)) begin
            j_q     <= '0;
            state_q <= S_ACT;
          end else begin
            j_q <= j_q + 8'd1;
          end
        end
        S_ACT: begin
          y_q[16*o_q +: 16] <= act_d;
          acc_q             <= '0;
          if (o_q == 8'(N-1)) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            o_q     <= o_q + 8'd1;
            state_q <= S_MAC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_dense_relu.sv
module tb_dense_relu;
  localparam int M     = 3;
  localparam int N     = 3;
  localparam int LAT   = N*(M+1);
  localparam int PERV  = LAT + 2;
`ifdef DENSE_RELU_ROUND_EN
  localparam logic [15:0] RND = 16'h0001;
`else
  localparam logic [15:0] RND = 16'h0000;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [16*M-1:0]   x;
  logic [16*M*N-1:0] weightsf;
  logic [16*N-1:0]   biasesf;
  logic              in_valid;
  logic              in_ready;
  logic [16*N-1:0]   y;
  logic              out_valid;
  logic              out_ready;

  dense_relu #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .x(x), .weightsf(weightsf), .biasesf(biasesf),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]     w_arr [M*N];
  logic [15:0]     b_arr [N];
  logic [16*N-1:0] exp_q [$];
  int              hs_q  [$];
  int tests = 0, fails = 0, n_out = 0, n_sent = 0;
  logic            prev_valid = 1'b0;
  logic [16*N-1:0] prev_y = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Reference: each output is floor-scaled sum of products, plus bias, clamped.
  function automatic logic [16*N-1:0] model(input logic [16*M-1:0] xv);
    logic [16*N-1:0] r;
    logic signed [15:0] xs, ws, bs;
    longint acc, p, s;
    real q;
    r = '0;
    for (int o = 0; o < N; o++) begin
      acc = 0;
      for (int j = 0; j < M; j++) begin
        xs = xv[16*j +: 16];
        ws = w_arr[o*M+j];
        p  = longint'(xs) * longint'(ws);
`ifdef DENSE_RELU_ROUND_EN
        q = $floor((real'(p) + 16384.0) / 32768.0);
`else
        q = $floor(real'(p) / 32768.0);
`endif
        acc += longint'(q);
      end
      bs = b_arr[o];
      s  = acc + longint'(bs);
      if (s <= 0)          r[16*o +: 16] = 16'h0000;
      else if (s > 32767)  r[16*o +: 16] = 16'h7FFF;
      else                 r[16*o +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic apply_params();
    for (int i = 0; i < M*N; i++) weightsf[16*i +: 16] = w_arr[i];
    for (int i = 0; i < N; i++)   biasesf[16*i +: 16]  = b_arr[i];
  endtask

  function automatic logic [16*M-1:0] pack3(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2);
    return {a2, a1, a0};
  endfunction

  // Monitor: pops the scoreboard on each output handshake, checks latency and hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (hs_q.size() == 0) flag("unexpected_out_valid");
        else check("latency", 64'(cyc - hs_q.pop_front()), 64'(LAT));
      end
      if (out_valid && prev_valid) check("y_stable", 64'(y), 64'(prev_y));
      if (out_valid) check("in_ready_in_done", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) flag("unexpected_output");
        else check("y", 64'(y), 64'(exp_q.pop_front()));
      end
      prev_valid = out_valid;
      prev_y     = y;
    end
  end

  task automatic send(input logic [16*M-1:0] xv, output int hs);
    int k;
    @(posedge clk); #1;
    x = xv;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    hs = 0;
    if (!in_ready) begin
      flag("send_timeout");
    end else begin
      exp_q.push_back(model(xv));
      hs = cyc + 1;
      hs_q.push_back(hs);
      n_sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) flag("wait_valid_timeout");
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 1000) flag("wait_idle_timeout");
  endtask

  task automatic set_w_all(input logic [15:0] v);
    for (int i = 0; i < M*N; i++) w_arr[i] = v;
  endtask

  task automatic set_b_all(input logic [15:0] v);
    for (int i = 0; i < N; i++) b_arr[i] = v;
  endtask

  initial begin
    int h, h0, h1, h2, n0;
    logic [16*N-1:0] held;
    logic [15:0] wv;
    x = '0; in_valid = 1'b0; out_ready = 1'b0; weightsf = '0; biasesf = '0;
    set_w_all(16'h0); set_b_all(16'h0); apply_params();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_y", 64'(y), 64'(0));
    rst = 1'b0;

    // Basic case with backpressure in DONE while in_valid pulses.
    set_w_all(16'h4000); set_b_all(16'h0000); apply_params();
    out_ready = 1'b0;
    send(pack3(16'h4000, 16'h4000, 16'h4000), h);
    wait_valid();
    check("basic_y", 64'(y), 64'({N{16'h6000}}));
    held = y;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_y_hold", 64'(y), 64'(held));
    end
    in_valid = 1'b0;
    n0 = n_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_one_handshake", 64'(n_out - n0), 64'(1));
    check("bp_valid_drop", 64'(out_valid), 64'(0));
    check("bp_in_ready_back", 64'(in_ready), 64'(1));

    // ReLU: output 1 weights negative, small positive bias.
    for (int j = 0; j < M; j++) w_arr[M+j] = 16'hC000;
    b_arr[1] = 16'h0100; apply_params();
    send(pack3(16'h4000, 16'h4000, 16'h4000), h);
    wait_idle();
    check("relu_y", 64'(y), 64'({16'h6000, 16'h0000, 16'h6000}));

    // Saturation high and negative bias below zero.
    set_w_all(16'h7FFF); set_b_all(16'h7FFF); apply_params();
    send(pack3(16'h7FFF, 16'h0000, 16'h0000), h);
    wait_idle();
    check("sat_high_y", 64'(y), 64'({N{16'h7FFF}}));
    set_b_all(16'h8000); apply_params();
    send(pack3(16'h7FFF, 16'h0000, 16'h0000), h);
    wait_idle();
    check("sat_neg_y", 64'(y), 64'(0));

    // Rounding of a half-LSB product, positive and negative.
    set_w_all(16'h0000); w_arr[0] = 16'h4000; set_b_all(16'h0000); apply_params();
    send(pack3(16'h0001, 16'h0000, 16'h0000), h);
    wait_idle();
    check("round_pos_y0", 64'(y[15:0]), 64'(RND));
    b_arr[0] = 16'h0001; apply_params();
    send(pack3(16'hFFFF, 16'h0000, 16'h0000), h);
    wait_idle();
    check("round_neg_y0", 64'(y[15:0]), 64'(RND));

    // Reset during output 1 of vector A, then vector B.
    set_w_all(16'h4000); set_b_all(16'h0000); apply_params();
    send(pack3(16'h4000, 16'h4000, 16'h4000), h);
    while (cyc < h + M + 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_y", 64'(y), 64'(0));
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    hs_q.delete();
    n_sent = n_out;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("rst_no_emit", 64'(out_valid), 64'(0));
    for (int i = 0; i < M*N; i++) w_arr[i] = 16'(16'h1000 + i * 16'h0400);
    b_arr[0] = 16'hF000; b_arr[1] = 16'h0200; b_arr[2] = 16'h0000; apply_params();
    n0 = n_out;
    send(pack3(16'h3000, 16'hE000, 16'h5000), h);
    wait_idle();
    check("rst_b_single_output", 64'(n_out - n0), 64'(1));

    // Random groups: back-to-back vectors with out_ready held high.
    out_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < M*N; i++) begin
        wv = 16'($urandom_range(0, 65535));
        if (g % 2 == 1) wv = {{3{wv[15]}}, wv[15:3]};
        w_arr[i] = wv;
      end
      for (int i = 0; i < N; i++) b_arr[i] = 16'($urandom_range(0, 65535));
      apply_params();
      send(16'($urandom) | (48'($urandom) << 16), h0);
      send(48'({$urandom, $urandom}), h1);
      send(48'({$urandom, $urandom}), h2);
      check("throughput_01", 64'(h1 - h0), 64'(PERV));
      check("throughput_12", 64'(h2 - h1), 64'(PERV));
      wait_idle();
    end

    // Random vectors with a random delay on out_ready.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < M*N; i++) w_arr[i] = 16'($urandom_range(0, 65535)) >> (v % 3);
      for (int i = 0; i < N; i++) b_arr[i] = 16'($urandom_range(0, 65535));
      apply_params();
      out_ready = 1'b0;
      send(48'({$urandom, $urandom}), h);
      wait_valid();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();
    end

    wait_idle();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("output_count", 64'(n_out), 64'(n_sent));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
